// File: rtl/register_bank_rw.sv
// rtl/register_bank_rw.sv - parametrised read/write register bank with init sweep and sticky errors
// Optional feature macro: REGISTER_BANK_PARITY_EN (per-word even parity, checked at the read output stage)
module register_bank_rw #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEMORY_SIZE  = 255,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  err_clr,
  output logic [3:0]            error_code
);

`ifdef REGISTER_BANK_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);

  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_RD_RANGE = 4'd1;
  localparam logic [3:0] ERR_WR_RANGE = 4'd2;
  localparam logic [3:0] ERR_PARITY   = 4'd3;
  localparam logic [3:0] ERR_BUSY     = 4'd4;

  // Storage; with parity enabled the parity bit sits in the MSB of each word.
  logic [WORD_W-1:0] mem [MEMORY_SIZE];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                  ready_q, ready_d;
  logic [3:0]            error_q, error_d;

  // First read stage (only meaningful when READ_LATENCY is 2) and output stage.
  logic                  s1_valid_q, s1_valid_d;
  logic [WORD_W-1:0]     s1_word_q, s1_word_d;
  logic                  out_valid_q, out_valid_d;
  logic [WORD_W-1:0]     out_word_q, out_word_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WORD_W-1:0]     mem_wdata;

  logic                  rd_accept, wr_accept;
  logic                  rd_in_range, wr_in_range;
  logic [WORD_W-1:0]     rd_word;
  logic                  parity_err;
  logic [3:0]            new_err;

  function automatic logic [WORD_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef REGISTER_BANK_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign ready      = ready_q;
  assign rd_valid   = out_valid_q;
  assign rd_data    = out_word_q[DATA_WIDTH-1:0];
  assign error_code = error_q;

  // Request qualification and the storage read (out-of-range reads return zero).
  always_comb begin
    rd_accept   = rd_en & ready_q;
    wr_accept   = wr_en & ready_q;
    rd_in_range = ({1'b0, rd_addr} < SIZE_EXT);
    wr_in_range = ({1'b0, wr_addr} < SIZE_EXT);
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
    end
  end

  // Init sweep FSM and storage write port selection (sweep owns the port while in INIT).
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = encode(wr_data);
    if (state_q == ST_INIT) begin
      mem_we     = 1'b1;
      mem_waddr  = init_ptr_q;
      mem_wdata  = '0;
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end else if (wr_accept && wr_in_range) begin
      mem_we = 1'b1;
    end
    ready_d = (state_d == ST_RUN);
  end

  // Read pipeline: zero-filled when idle so rd_data reads 0 outside rd_valid.
  always_comb begin
    s1_valid_d = rd_accept;
    s1_word_d  = rd_accept ? rd_word : '0;
    if (READ_LATENCY == 2) begin
      out_valid_d = s1_valid_q;
      out_word_d  = s1_word_q;
    end else begin
      out_valid_d = s1_valid_d;
      out_word_d  = s1_word_d;
    end
  end

  // Sticky error capture: lowest code wins among same-cycle errors; a clear still lets a new error in.
  always_comb begin
    parity_err = 1'b0;
`ifdef REGISTER_BANK_PARITY_EN
    parity_err = out_valid_q & (^out_word_q);
`endif
    new_err = ERR_NONE;
    if (!ready_q && (rd_en || wr_en)) new_err = ERR_BUSY;
    if (parity_err)                   new_err = ERR_PARITY;
    if (wr_accept && !wr_in_range)    new_err = ERR_WR_RANGE;
    if (rd_accept && !rd_in_range)    new_err = ERR_RD_RANGE;
    error_d = err_clr ? ERR_NONE : error_q;
    if (error_d == ERR_NONE) begin
      error_d = new_err;
    end
  end

  // Control state, read pipeline and error register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_ptr_q  <= '0;
      ready_q     <= 1'b0;
      error_q     <= ERR_NONE;
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      s1_valid_q  <= s1_valid_d;
      s1_word_q   <= s1_word_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

  // Storage write port; reads sample the old word, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_register_bank_rw.sv
// tb/tb_register_bank_rw.sv - bench for register_bank_rw at read latencies 1 and 2
module tb_register_bank_rw;
  localparam int MS = 255;

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, err_clr;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        ready1, rd_valid1, ready2, rd_valid2;
  logic [31:0] rd_data1, rd_data2;
  logic [3:0]  err1, err2;

  always #5 clk = ~clk;

  register_bank_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEMORY_SIZE(MS), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .reset(reset), .ready(ready1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .err_clr(err_clr), .error_code(err1));

  register_bank_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEMORY_SIZE(MS), .READ_LATENCY(2)) u_rl2 (
    .clk(clk), .reset(reset), .ready(ready2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .err_clr(err_clr), .error_code(err2));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    int          lat;
    logic [31:0] data;
    bit          bad;
  } rd_ent_t;

  rd_ent_t     pend[$];
  logic [31:0] mem_m [256];
  bit          bad_m [256];
  int          low_cycles = 0;
  int          now = 0;
  logic [3:0]  err_m [2];
  logic [3:0]  cand [2];
  bit          model_on = 1'b0;
  bit          rdy_m;
  logic [31:0] rd_m;
  bit          rd_bad_m;
  bit          exp_v [2];
  logic [31:0] exp_d [2];

  function automatic logic [3:0] lowest(input logic [3:0] a, input logic [3:0] b);
    if (a == 0) return b;
    if (b == 0) return a;
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      low_cycles = 0;
      pend.delete();
      err_m[0] = 0;
      err_m[1] = 0;
      model_on = 1'b1;
    end else begin
      rdy_m = (low_cycles >= MS);
      cand[0] = 0;
      cand[1] = 0;
      foreach (pend[i]) begin
        if (pend[i].due == now && pend[i].bad) cand[pend[i].lat-1] = lowest(cand[pend[i].lat-1], 4'd3);
      end
      if (!rdy_m) begin
        if (rd_en || wr_en) begin
          cand[0] = lowest(cand[0], 4'd4);
          cand[1] = lowest(cand[1], 4'd4);
        end
      end else begin
        if (rd_en) begin
          rd_m = 0;
          rd_bad_m = 0;
          if (rd_addr < MS) begin
            rd_m = mem_m[rd_addr];
            rd_bad_m = bad_m[rd_addr];
          end else begin
            cand[0] = lowest(cand[0], 4'd1);
            cand[1] = lowest(cand[1], 4'd1);
          end
          pend.push_back('{now + 1, 1, rd_m, rd_bad_m});
          pend.push_back('{now + 2, 2, rd_m, rd_bad_m});
        end
        if (wr_en) begin
          if (wr_addr < MS) begin
            mem_m[wr_addr] = wr_data;
            bad_m[wr_addr] = 0;
          end else begin
            cand[0] = lowest(cand[0], 4'd2);
            cand[1] = lowest(cand[1], 4'd2);
          end
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (err_clr) err_m[l] = 0;
        if (err_m[l] == 0) err_m[l] = cand[l];
      end
      low_cycles++;
      if (low_cycles == MS) begin
        for (int a = 0; a < 256; a++) begin
          mem_m[a] = 0;
          bad_m[a] = 0;
        end
      end
    end
    while (pend.size() > 0 && pend[0].due <= now) void'(pend.pop_front());
    now++;
  end

  // Compare both DUTs against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (model_on) begin
      exp_v[0] = 0; exp_v[1] = 0;
      exp_d[0] = 0; exp_d[1] = 0;
      foreach (pend[i]) begin
        if (pend[i].due == now) begin
          exp_v[pend[i].lat-1] = 1;
          exp_d[pend[i].lat-1] = pend[i].data;
        end
      end
      chk("m_ready1", ready1, (low_cycles >= MS) ? 1 : 0);
      chk("m_ready2", ready2, (low_cycles >= MS) ? 1 : 0);
      chk("m_valid1", rd_valid1, exp_v[0]);
      chk("m_valid2", rd_valid2, exp_v[1]);
      chk("m_data1", rd_data1, exp_d[0]);
      chk("m_data2", rd_data2, exp_d[1]);
      chk("m_err1", err1, err_m[0]);
      chk("m_err2", err2, err_m[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0;
    rd_en = 0;
    err_clr = 0;
  endtask

  task automatic read_chk(input logic [7:0] addr, input logic [31:0] exp, input string name);
    rd_en = 1;
    rd_addr = addr;
    step();
    rd_en = 0;
    @(negedge clk);
    chk({name, "_v1"}, rd_valid1, 1);
    chk({name, "_d1"}, rd_data1, exp);
    chk({name, "_v2early"}, rd_valid2, 0);
    @(negedge clk);
    chk({name, "_v2"}, rd_valid2, 1);
    chk({name, "_d2"}, rd_data2, exp);
    chk({name, "_v1off"}, rd_valid1, 0);
    step();
  endtask

  task automatic write(input logic [7:0] addr, input logic [31:0] data);
    wr_en = 1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en = 0;
  endtask

  int ready_at;

  initial begin
    reset = 1;
    idle();
    wr_addr = 0;
    wr_data = 0;
    rd_addr = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", ready1, 0);
    chk("rst_valid", rd_valid1, 0);
    chk("rst_data", rd_data2, 0);
    chk("rst_err", err1, 0);
    step();
    reset = 0;

    // Init sweep with a write attempted while busy.
    ready_at = -1;
    for (int i = 0; i < 300 && ready_at < 0; i++) begin
      if (i == 5) begin
        wr_en = 1; wr_addr = 8'h05; wr_data = 32'hAAAA5555;
      end else begin
        wr_en = 0;
      end
      @(negedge clk);
      if (ready1) ready_at = i;
      if (i == 8) begin
        chk("busy_err1", err1, 4);
        chk("busy_err2", err2, 4);
      end
      step();
    end
    chk("ready_cycle", ready_at, 255);
    err_clr = 1;
    step();
    err_clr = 0;
    @(negedge clk);
    chk("busy_clr", err1, 0);
    step();

    read_chk(8'h00, 32'h0, "init00");
    read_chk(8'h7F, 32'h0, "init7f");
    read_chk(8'hFE, 32'h0, "initfe");
    read_chk(8'h05, 32'h0, "busy_dropped");

    write(8'h10, 32'hDEADBEEF);
    read_chk(8'h10, 32'hDEADBEEF, "wr_rd");

    // Out of range, stickiness and clear.
    read_chk(8'hFF, 32'h0, "oor_rd");
    @(negedge clk);
    chk("oor_err1", err1, 1);
    chk("oor_err2", err2, 1);
    write(8'hFF, 32'h12345678);
    @(negedge clk);
    chk("sticky", err1, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    @(negedge clk);
    chk("clr", err1, 0);
    step();

    // Read-before-write collision.
    write(8'h20, 32'h1);
    wr_en = 1; wr_addr = 8'h20; wr_data = 32'h2;
    rd_en = 1; rd_addr = 8'h20;
    step();
    idle();
    @(negedge clk);
    chk("coll_old1", rd_data1, 32'h1);
    @(negedge clk);
    chk("coll_old2", rd_data2, 32'h1);
    step();
    read_chk(8'h20, 32'h2, "coll_new");

    // Back-to-back reads, checked by the model.
    for (int k = 0; k < 3; k++) begin
      rd_en = 1;
      rd_addr = (k == 0) ? 8'h10 : (k == 1) ? 8'h20 : 8'h00;
      step();
    end
    idle();
    repeat (3) step();

    // Simultaneous errors: lowest code wins; clear with a new error loads it.
    wr_en = 1; wr_addr = 8'hFF; rd_en = 1; rd_addr = 8'hFF;
    step();
    idle();
    @(negedge clk);
    chk("multi_err", err1, 1);
    wr_en = 1; wr_addr = 8'hFF; err_clr = 1;
    step();
    idle();
    @(negedge clk);
    chk("clr_load", err2, 2);
    err_clr = 1;
    step();
    idle();
    step();

`ifdef REGISTER_BANK_PARITY_EN
    u_rl1.mem[16][0] = ~u_rl1.mem[16][0];
    u_rl2.mem[16][0] = ~u_rl2.mem[16][0];
    mem_m[16] = mem_m[16] ^ 32'h1;
    bad_m[16] = 1;
    read_chk(8'h10, 32'hDEADBEEE, "par");
    @(negedge clk);
    chk("par_err1", err1, 3);
    chk("par_err2", err2, 3);
    err_clr = 1;
    step();
    idle();
    step();
`endif

    // Reset one cycle after a read request.
    rd_en = 1; rd_addr = 8'h10;
    step();
    rd_en = 0;
    reset = 1;
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_flush_v2", rd_valid2, 0);
      chk("rst_ready_drop", ready1, 0);
      step();
    end
    reset = 0;
    ready_at = -1;
    for (int i = 0; i < 300 && ready_at < 0; i++) begin
      @(negedge clk);
      if (ready2) ready_at = i;
      step();
    end
    chk("resweep_cycle", ready_at, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
